// File: rtl/fault_sweep_ctrl.sv
// fault_sweep_ctrl: exhaustive stuck-at sweep comparing golden and faulty circuit responses per pattern.
module fault_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop_on_first,
  output logic [N_IN-1:0]   pattern,
  input  logic [N_OUT-1:0]  good_resp,
  input  logic [N_OUT-1:0]  dut_resp,
  output logic              busy,
  output logic              done,
  output logic              detected,
  output logic [N_IN-1:0]   first_vec,
  output logic [N_OUT-1:0]  first_diff,
  output logic [N_IN:0]     mismatch_cnt
);
  typedef enum logic [1:0] {IDLE, APPLY, CMP, DONE} state_t;
  localparam logic [3:0]    L_LAST = SETTLE == 0 ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] P_ONE = 1;
  localparam logic [N_IN:0] C_ONE = 1;
  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_sof, r_busy, r_done, r_det;
  logic [N_IN-1:0]   r_pat, r_first_vec;
  logic [N_OUT-1:0]  r_first_diff;
  logic [N_IN:0]     r_mcnt;
  logic [N_OUT-1:0]  w_diff;
  logic              w_mis, w_end;
  assign w_diff = good_resp ^ dut_resp;
  assign w_mis  = |w_diff;
  // the sweep stops at all ones so pattern never wraps
  assign w_end  = (&r_pat) || (r_sof && w_mis);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (SETTLE == 0 ? CMP : APPLY) : IDLE;
      APPLY:   w_next = r_cnt == L_LAST ? CMP : APPLY;
      CMP:     w_next = w_end ? DONE : (SETTLE == 0 ? CMP : APPLY);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sof <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_det <= 1'b0;
      r_pat <= '0;
      r_first_vec <= '0;
      r_first_diff <= '0;
      r_mcnt <= '0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == CMP && w_end;
      case (r_state)
        IDLE: if (start) begin
          r_pat <= '0;
          r_busy <= 1'b1;
          r_det <= 1'b0;
          r_first_vec <= '0;
          r_first_diff <= '0;
          r_mcnt <= '0;
          r_sof <= stop_on_first;
          r_cnt <= '0;
        end
        APPLY: r_cnt <= r_cnt == L_LAST ? 4'd0 : r_cnt + 4'd1;
        CMP: begin
          if (w_mis) r_mcnt <= r_mcnt + C_ONE;
          if (w_mis && !r_det) begin
            r_det <= 1'b1;
            r_first_vec <= r_pat;
            r_first_diff <= w_diff;
          end
          if (w_end) r_busy <= 1'b0;
          else r_pat <= r_pat + P_ONE;
        end
        default: ;
      endcase
    end
  end
  assign pattern      = r_pat;
  assign busy         = r_busy;
  assign done         = r_done;
  assign detected     = r_det;
  assign first_vec    = r_first_vec;
  assign first_diff   = r_first_diff;
  assign mismatch_cnt = r_mcnt;
endmodule

// File: tb/tb_fault_sweep_ctrl.sv
// tb_fault_sweep_ctrl: directed checks of the sweep controller with SETTLE=1 and SETTLE=0 instances.
module tb_fault_sweep_ctrl;
  logic clk = 0, rst = 1, start = 0, sof = 0, start0 = 0, fault = 0;
  logic [2:0] pat, fv, pat0, fv0;
  logic [1:0] good, dut, fd, good0, dut0, fd0;
  logic [3:0] mc, mc0;
  logic busy, done, det, busy0, done0, det0;
  int checks = 0, errors = 0, n, seen;
  always #5 clk = ~clk;
  assign good  = {pat[2] & pat[1], pat[1] ^ pat[0]};
  assign dut   = fault ? {1'b1, good[0]} : good;
  assign good0 = {pat0[2] & pat0[1], pat0[1] ^ pat0[0]};
  assign dut0  = fault ? {1'b1, good0[0]} : good0;
  fault_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_first(sof), .pattern(pat),
    .good_resp(good), .dut_resp(dut), .busy(busy), .done(done), .detected(det),
    .first_vec(fv), .first_diff(fd), .mismatch_cnt(mc));
  fault_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop_on_first(1'b0), .pattern(pat0),
    .good_resp(good0), .dut_resp(dut0), .busy(busy0), .done(done0), .detected(det0),
    .first_vec(fv0), .first_diff(fd0), .mismatch_cnt(mc0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic s);
    start = 1; sof = s;
    @(posedge clk); #1;
    start = 0; sof = 0;
  endtask
  task automatic wait_done(input int n0, output int nn);
    nn = n0;
    while (!done && nn < 40) begin @(posedge clk); #1; nn++; end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_det", det, 0);
    chk("rst_pat", pat, 0); chk("rst_mcnt", mc, 0);
    rst = 0;
    @(posedge clk); #1;
    fault = 0; go(0);
    chk("s1_pat0", pat, 0); chk("s1_busy", busy, 1);
    wait_done(1, n);
    chk("s1_done_cyc", n, 17); chk("s1_det", det, 0); chk("s1_mcnt", mc, 0);
    chk("s1_pat_last", pat, 7); chk("s1_busy_done", busy, 0);
    @(posedge clk); #1;
    chk("s1_done_pulse", done, 0);
    fault = 1; go(0);
    wait_done(1, n);
    chk("s2_done_cyc", n, 17); chk("s2_det", det, 1); chk("s2_fv", fv, 0);
    chk("s2_fd", fd, 2); chk("s2_mcnt", mc, 6);
    @(posedge clk); #1;
    go(1);
    wait_done(1, n);
    chk("s3_done_cyc", n, 3); chk("s3_mcnt", mc, 1); chk("s3_fv", fv, 0);
    chk("s3_pat", pat, 0);
    @(posedge clk); #1;
    start0 = 1;
    @(posedge clk); #1;
    start0 = 0; n = 1;
    while (!done0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("s4_done_cyc", n, 9); chk("s4_mcnt", mc0, 6); chk("s4_fd", fd0, 2);
    chk("s4_pat", pat0, 7);
    @(posedge clk); #1;
    go(0);
    repeat (5) @(posedge clk);
    #1;
    chk("s5_pre_det", det, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("s5_busy", busy, 0); chk("s5_pat", pat, 0); chk("s5_det", det, 0);
    chk("s5_mcnt", mc, 0); chk("s5_fd", fd, 0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) seen++; end
    chk("s5_no_done", seen, 0);
    go(0);
    wait_done(1, n);
    chk("s5_done_cyc", n, 17); chk("s5_mcnt2", mc, 6); chk("s5_fd2", fd, 2);
    @(posedge clk); #1;
    go(0);
    repeat (4) @(posedge clk);
    #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(6, n);
    chk("s6_done_cyc", n, 17); chk("s6_mcnt", mc, 6); chk("s6_fv", fv, 0);
    @(posedge clk); #1;
    chk("s6_idle_busy", busy, 0);
    fault = 0; go(0);
    chk("s6_clr_det", det, 0); chk("s6_clr_mcnt", mc, 0); chk("s6_clr_fd", fd, 0);
    wait_done(1, n);
    chk("s6_done_cyc2", n, 17); chk("s6_mcnt2", mc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fault_sweep_ctrl.md
Name: fault_sweep_ctrl

Overview:
Synthesisable exhaustive stuck-at fault sweep controller. On a start request it drives all 2^N_IN input patterns, in order, to a golden circuit and a fault-injected circuit. It compares their responses after a programmable settle time and reports the detection result, the first failing pattern and the total mismatch count. It replaces fixed-width, time-delay stimulus benches with an on-chip, clocked sweep for any input/output width.

Parameters:
N_IN, 3, number of circuit inputs; 1..16; sweep length is 2^N_IN patterns.
N_OUT, 2, number of circuit outputs compared; 1..32.
SETTLE, 1, cycles a pattern is held before its response is sampled; 0..15.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; sampled only in IDLE.
stop_on_first  input  1  end the sweep at the first mismatch; sampled with start.
pattern  output  N_IN  input vector driven to both circuits.
good_resp  input  N_OUT  golden circuit outputs.
dut_resp  input  N_OUT  fault-injected circuit outputs.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep ends.
detected  output  1  at least one mismatch in the last sweep; held.
first_vec  output  N_IN  pattern of the first mismatch; held.
first_diff  output  N_OUT  good_resp XOR dut_resp at the first mismatch; held.
mismatch_cnt  output  N_IN+1  number of mismatching patterns; held.

Behaviour:
- Reset (sync, active-high, highest priority, valid in any state):
  - state=IDLE; all outputs 0; settle counter and stop_on_first latch cleared.
  - Reset during a sweep abandons it. No done pulse is issued.
- States: IDLE, APPLY, CMP, DONE.
- IDLE:
  - start=1 at edge k → APPLY at k+1.
  - At edge k: pattern=0, busy=1, detected/first_vec/first_diff/mismatch_cnt cleared, stop_on_first latched.
- APPLY:
  - Holds pattern for SETTLE cycles, then goes to CMP.
  - If SETTLE=0, the start edge goes directly to CMP and APPLY is never entered.
- CMP (one cycle): compare good_resp against dut_resp.
  - On mismatch: mismatch_cnt += 1.
  - If this is the first mismatch of the sweep, set detected=1, first_vec=pattern, first_diff=good_resp^dut_resp.
- CMP exit:
  - Last pattern (all ones), or latched stop_on_first with a mismatch this cycle → DONE.
  - Otherwise pattern += 1 and go to APPLY (or stay in CMP when SETTLE=0).
- DONE (one cycle): done=1, busy=0, then return to IDLE.
  - pattern holds its last value until the next start.
  - Result outputs hold until the next start or reset.
- Timing, start sampled at edge k:
  - Pattern v is compared in cycle k+1+v*(SETTLE+1)+SETTLE.
  - Full sweep: done is high in cycle k+1+2^N_IN*(SETTLE+1).
- pattern never wraps. Incrementing beyond all ones is forbidden; the sweep terminates there.
- mismatch_cnt is wide enough to hold 2^N_IN with no saturation logic.
- start while busy or in DONE is ignored. No queued request.
- start is level-sampled: if still high in the cycle after DONE (IDLE), a new sweep begins.
- Responses are sampled only in CMP. Changes on good_resp/dut_resp at other times have no effect.

Test Plan:
1. N_IN=3, SETTLE=1, dut_resp==good_resp for all patterns, start pulse at edge k → pattern steps 0..7; done at cycle k+17; detected=0, mismatch_cnt=0.
2. good_resp={A&B, B^C} with pattern={A,B,C}; dut_resp[1] stuck at 1 → detected=1, first_vec=3'b000, first_diff=2'b10, mismatch_cnt=6, done at k+17.
3. Same fault as scenario 2 with stop_on_first=1 → done at k+3, mismatch_cnt=1, first_vec=3'b000, pattern holds 3'b000.
4. SETTLE=0, fault as scenario 2 → one compare per cycle; done at k+9; mismatch_cnt=6.
5. rst asserted at k+6 mid-sweep → next cycle all outputs 0, state IDLE, no done pulse; a fresh start then gives the full scenario-2 result.
6. start re-pulsed at k+5 while busy → ignored; sweep and results identical to scenario 2; a new start after done clears the results first.
